// File: rtl/thr_pkg.sv
// Shared frame markers and state encodings for the frame threshold trigger slice.
package thr_pkg;

    localparam logic [15:0] START_WORD = 16'hDEAD;
    localparam logic [15:0] END_WORD   = 16'hBEEF;

    typedef enum logic [1:0] {IDLE, TS, DATA, END} parser_state_t;
    typedef enum logic       {ARMED, ACTIVE}       trig_state_t;

endpackage

// File: rtl/thr_frame_parser.sv
// One-lane DEAD/TS/data/BEEF frame parser with time stamp latch, threshold compare,
// registered hit flag and framing-error pulse.
module thr_frame_parser
    import thr_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        syncstatus,
    input  logic [1:0]        datak,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] threshold,
    input  logic              trig_below,
    output logic              hit_q,
    output logic [DATA_W-1:0] ts,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    // Counts 0..FRAME_LEN-4, i.e. FRAME_LEN-3 samples between the TS and END words.
    localparam logic [CNT_W-1:0]  LAST_SAMPLE = CNT_W'(FRAME_LEN - 4);
    localparam logic [DATA_W-1:0] START_VAL   = DATA_W'(START_WORD);
    localparam logic [DATA_W-1:0] END_VAL     = DATA_W'(END_WORD);

    parser_state_t     state, state_d;
    logic [CNT_W-1:0]  word_cnt, word_cnt_d;
    logic [DATA_W-1:0] ts_d;
    logic              hit_d;
    logic              err_d;
    logic              in_sync;
    logic              valid;

    assign in_sync = (syncstatus == 2'b11);
    assign valid   = in_sync && (datak == 2'b00);

    always_comb begin
        state_d    = state;
        word_cnt_d = word_cnt;
        ts_d       = ts;
        hit_d      = 1'b0;
        err_d      = 1'b0;
        if (state != IDLE && !in_sync) begin
            err_d   = 1'b1;
            state_d = IDLE;
        end else if (valid) begin
            case (state)
                IDLE: begin
                    if (data == START_VAL) state_d = TS;
                end
                TS: begin
                    ts_d       = data;
                    word_cnt_d = '0;
                    state_d    = DATA;
                end
                DATA: begin
                    hit_d = trig_below ? (data < threshold) : (data > threshold);
                    if (word_cnt == LAST_SAMPLE) state_d = END;
                    else                         word_cnt_d = word_cnt + 1'b1;
                end
                END: begin
                    if (data != END_VAL) err_d = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            word_cnt  <= '0;
            ts        <= '0;
            hit_q     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            word_cnt  <= word_cnt_d;
            ts        <= ts_d;
            hit_q     <= hit_d;
            frame_err <= err_d;
        end
    end

endmodule

// File: rtl/frame_threshold_trigger.sv
// N-lane framed threshold trigger for the DRAM controller.
// Define THRESH_COINCIDENCE_EN to require MIN_COINC enabled lanes hitting in the same cycle.
module frame_threshold_trigger
    import thr_pkg::*;
#(
    parameter int          NUM_CH              = 8,
    parameter int          DATA_W              = 16,
    parameter int          FRAME_LEN           = 128,
    parameter logic [15:0] POST_TRIGGER_ENDING = 16'd10,
    parameter int          MIN_COINC           = 2,
    localparam int         CH_W                = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     rx_std_clkout,
    input  logic                     rst,
    input  logic [2*NUM_CH-1:0]      rx_syncstatus,
    input  logic [2*NUM_CH-1:0]      rx_datak,
    input  logic [DATA_W*NUM_CH-1:0] RX_data,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic [DATA_W-1:0]        threshold,
    input  logic                     trig_below,
    output logic                     threshold_decision_to_DRAM_ctrl,
    output logic [DATA_W-1:0]        triggering_time_stamp,
    output logic [CH_W-1:0]          trigger_channel,
    output logic [15:0]              trig_count,
    output logic [NUM_CH-1:0]        frame_err
);

    if (NUM_CH < 1 || NUM_CH > 16 || FRAME_LEN < 4 || POST_TRIGGER_ENDING < 16'd1
        || MIN_COINC < 1 || MIN_COINC > NUM_CH) begin : g_bad_params
        $error("frame_threshold_trigger: parameter out of range");
    end

    logic [NUM_CH-1:0] hit_q;
    logic [DATA_W-1:0] lane_ts [NUM_CH];
    logic [NUM_CH-1:0] qual;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        thr_frame_parser #(
            .DATA_W   (DATA_W),
            .FRAME_LEN(FRAME_LEN)
        ) u_parser (
            .clk       (rx_std_clkout),
            .rst       (rst),
            .syncstatus(rx_syncstatus[2*i +: 2]),
            .datak     (rx_datak[2*i +: 2]),
            .data      (RX_data[DATA_W*i +: DATA_W]),
            .threshold (threshold),
            .trig_below(trig_below),
            .hit_q     (hit_q[i]),
            .ts        (lane_ts[i]),
            .frame_err (frame_err[i])
        );
    end

    assign qual = hit_q & ch_enable;

    // Scanning from the top down leaves the lowest set lane as the winner.
    logic [CH_W-1:0]   win_ch;
    logic [DATA_W-1:0] win_ts;

    always_comb begin
        win_ch = '0;
        win_ts = '0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (qual[i-1]) begin
                win_ch = CH_W'(i - 1);
                win_ts = lane_ts[i-1];
            end
        end
    end

    logic trig_cond;

`ifdef THRESH_COINCIDENCE_EN
    int unsigned hit_pop;

    always_comb begin
        hit_pop = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            hit_pop = hit_pop + 32'(qual[i]);
        end
        trig_cond = (hit_pop >= 32'(MIN_COINC));
    end
`else
    assign trig_cond = |qual;
`endif

    localparam logic [15:0] HOLD_RELOAD = POST_TRIGGER_ENDING - 16'd1;

    trig_state_t       state, state_d;
    logic [15:0]       hold_cnt, hold_cnt_d;
    logic              decision_d;
    logic [DATA_W-1:0] ts_d;
    logic [CH_W-1:0]   ch_d;
    logic [15:0]       count_d;

    always_comb begin
        state_d    = state;
        hold_cnt_d = hold_cnt;
        decision_d = threshold_decision_to_DRAM_ctrl;
        ts_d       = triggering_time_stamp;
        ch_d       = trigger_channel;
        count_d    = trig_count;
        case (state)
            ARMED: begin
                if (trig_cond) begin
                    decision_d = 1'b1;
                    ts_d       = win_ts;
                    ch_d       = win_ch;
                    count_d    = trig_count + 16'd1;
                    hold_cnt_d = HOLD_RELOAD;
                    state_d    = ACTIVE;
                end
            end
            ACTIVE: begin
                if (trig_cond) begin
                    hold_cnt_d = HOLD_RELOAD;
                end else if (hold_cnt == 16'd0) begin
                    decision_d = 1'b0;
                    state_d    = ARMED;
                end else begin
                    hold_cnt_d = hold_cnt - 16'd1;
                end
            end
            default: state_d = ARMED;
        endcase
    end

    always_ff @(posedge rx_std_clkout) begin
        if (rst) begin
            state                           <= ARMED;
            hold_cnt                        <= '0;
            threshold_decision_to_DRAM_ctrl <= 1'b0;
            triggering_time_stamp           <= '0;
            trigger_channel                 <= '0;
            trig_count                      <= '0;
        end else begin
            state                           <= state_d;
            hold_cnt                        <= hold_cnt_d;
            threshold_decision_to_DRAM_ctrl <= decision_d;
            triggering_time_stamp           <= ts_d;
            trigger_channel                 <= ch_d;
            trig_count                      <= count_d;
        end
    end

endmodule

// File: tb/tb_frame_threshold_trigger.sv
// Self-checking bench for frame_threshold_trigger: table-driven frames, hand-written
// corner sequences and a randomized run against a window-union reference model.
module tb_frame_threshold_trigger;

    localparam int NCH = 8;
    localparam int DW  = 16;
    localparam int FL  = 128;
    localparam int P   = 10;
    localparam int LOG = 160;

    logic              clk = 1'b0;
    logic              rst;
    logic [2*NCH-1:0]  ss_bus, dk_bus;
    logic [DW*NCH-1:0] data_bus;
    logic [NCH-1:0]    en;
    logic [DW-1:0]     thr;
    logic              tbl;
    logic              dec;
    logic [DW-1:0]     tts;
    logic [2:0]        tch;
    logic [15:0]       tcnt;
    logic [NCH-1:0]    ferr;

    always #5 clk = ~clk;

    frame_threshold_trigger #(
        .NUM_CH             (NCH),
        .DATA_W             (DW),
        .FRAME_LEN          (FL),
        .POST_TRIGGER_ENDING(16'(P)),
        .MIN_COINC          (2)
    ) dut (
        .rx_std_clkout                  (clk),
        .rst                            (rst),
        .rx_syncstatus                  (ss_bus),
        .rx_datak                       (dk_bus),
        .RX_data                        (data_bus),
        .ch_enable                      (en),
        .threshold                      (thr),
        .trig_below                     (tbl),
        .threshold_decision_to_DRAM_ctrl(dec),
        .triggering_time_stamp          (tts),
        .trigger_channel                (tch),
        .trig_count                     (tcnt),
        .frame_err                      (ferr)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    logic [15:0] lane_ts_c [NCH] = '{16'h0000, 16'h0010, 16'h0100, 16'h1000,
                                     16'h1010, 16'h00F0, 16'h0FF0, 16'hFF00};
    logic [15:0] w [NCH];
    logic [1:0]  s [NCH];
    logic [1:0]  d [NCH];

    task automatic step();
        for (int l = 0; l < NCH; l++) begin
            data_bus[DW*l +: DW] = w[l];
            ss_bus[2*l +: 2]     = s[l];
            dk_bus[2*l +: 2]     = d[l];
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [15:0]    fw   [NCH][FL];
    logic [1:0]     fs   [NCH][FL];
    logic           frst [FL];
    logic [LOG-1:0] dec_log;
    logic [LOG-1:0] err_log [NCH];

    task automatic init_frame(input logic [15:0] base);
        for (int l = 0; l < NCH; l++) begin
            for (int k = 0; k < FL; k++) begin
                fw[l][k] = (k == 0) ? 16'hDEAD : (k == 1) ? lane_ts_c[l] :
                           (k == FL - 1) ? 16'hBEEF : base;
                fs[l][k] = 2'b11;
            end
        end
        for (int k = 0; k < FL; k++) frst[k] = 1'b0;
    endtask

    // Plays one frame on every lane in lockstep, then idle fillers; log index k is the
    // sample taken after the clock edge that consumed input word k.
    task automatic play();
        for (int k = 0; k < LOG; k++) begin
            rst = (k < FL) ? frst[k] : 1'b0;
            for (int l = 0; l < NCH; l++) begin
                if (k < FL) begin
                    w[l] = fw[l][k]; s[l] = fs[l][k]; d[l] = 2'b00;
                end else begin
                    w[l] = 16'h0; s[l] = 2'b11; d[l] = 2'b01;
                end
            end
            step();
            dec_log[k] = dec;
            for (int l = 0; l < NCH; l++) err_log[l][k] = ferr[l];
        end
    endtask

    // Decision is high on log index k iff some qualifying word h satisfies h+1 <= k <= h+P.
    function automatic logic [LOG-1:0] win(input int h1, input int h2);
        logic [LOG-1:0] v;
        v = '0;
        for (int k = 0; k < LOG; k++) begin
            if ((h1 >= 0 && k >= h1 + 1 && k <= h1 + P) || (h2 >= 0 && k >= h2 + 1 && k <= h2 + P))
                v[k] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [NCH-1:0] err_any();
        logic [NCH-1:0] e;
        for (int l = 0; l < NCH; l++) e[l] = |err_log[l];
        return e;
    endfunction

    function automatic int lowest(input logic [NCH-1:0] q);
        for (int i = 0; i < NCH; i++) if (q[i]) return i;
        return 0;
    endfunction

    typedef struct {
        int          la;
        logic [15:0] va;
        int          lb;
        logic [15:0] vb;
        logic [7:0]  en;
        logic        below;
        logic [15:0] base;
        logic        trig;
        logic [2:0]  ch;
        logic [15:0] ts;
    } vec_t;

    vec_t vecs[$];
    int   exp_cnt;
    logic [2:0]  exp_ch;
    logic [15:0] exp_ts;

    // Random-run model state
    int             pos      [NCH];
    logic [15:0]    cur_ts   [NCH];
    logic [15:0]    hit_ts   [NCH];
    logic [15:0]    prev_ts  [NCH];
    logic [NCH-1:0] hits, prev_hits, qual;
    logic           cond, dec_prev, dec_exp;
    int             last_cond;
    logic [15:0]    v;

    initial begin
`ifdef THRESH_COINCIDENCE_EN
        vecs.push_back('{3, 16'h0200, -1, 16'h0, 8'hFF, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000});
        vecs.push_back('{4, 16'h0200,  6, 16'h0200, 8'hFF, 1'b0, 16'h0000, 1'b1, 3'd4, 16'h1010});
        vecs.push_back('{2, 16'h0200,  5, 16'h0200, 8'hFB, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000});
        vecs.push_back('{2, 16'h0200,  5, 16'h0200, 8'hFF, 1'b0, 16'h0000, 1'b1, 3'd2, 16'h0100});
        vecs.push_back('{1, 16'h00FF,  6, 16'h0080, 8'hFF, 1'b1, 16'h0100, 1'b1, 3'd1, 16'h0010});
        vecs.push_back('{0, 16'h0100,  7, 16'h0100, 8'hFF, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000});
`else
        vecs.push_back('{3, 16'h0200, -1, 16'h0, 8'hFF, 1'b0, 16'h0000, 1'b1, 3'd3, 16'h1000});
        vecs.push_back('{3, 16'h0100, -1, 16'h0, 8'hFF, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000});
        vecs.push_back('{2, 16'h0200,  5, 16'h0200, 8'hFF, 1'b0, 16'h0000, 1'b1, 3'd2, 16'h0100});
        vecs.push_back('{2, 16'h0200,  5, 16'h0200, 8'hFB, 1'b0, 16'h0000, 1'b1, 3'd5, 16'h00F0});
        vecs.push_back('{6, 16'h00FF, -1, 16'h0, 8'hFF, 1'b1, 16'h0100, 1'b1, 3'd6, 16'h0FF0});
        vecs.push_back('{1, 16'h0101, -1, 16'h0, 8'hFF, 1'b1, 16'h0100, 1'b0, 3'd0, 16'h0000});
        vecs.push_back('{7, 16'hDEAD, -1, 16'h0, 8'hFF, 1'b0, 16'h0000, 1'b1, 3'd7, 16'hFF00});
        vecs.push_back('{0, 16'hBEEF, -1, 16'h0, 8'hFF, 1'b0, 16'h0000, 1'b1, 3'd0, 16'h0000});
        vecs.push_back('{4, 16'h0200, -1, 16'h0, 8'hEF, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000});
`endif

        rst = 1'b1; en = 8'hFF; thr = 16'h0100; tbl = 1'b0;
        for (int l = 0; l < NCH; l++) begin w[l] = 16'h0; s[l] = 2'b11; d[l] = 2'b01; end
        repeat (3) step();
        check("reset_decision", dec, 1'b0);
        check("reset_ts", tts, 16'h0);
        check("reset_channel", tch, 3'd0);
        check("reset_count", tcnt, 16'h0);
        check("reset_frame_err", ferr, 8'h0);
        rst = 1'b0;
        exp_cnt = 0; exp_ch = '0; exp_ts = '0;

        foreach (vecs[i]) begin
            en  = vecs[i].en;
            tbl = vecs[i].below;
            init_frame(vecs[i].base);
            fw[vecs[i].la][10] = vecs[i].va;
            if (vecs[i].lb >= 0) fw[vecs[i].lb][10] = vecs[i].vb;
            play();
            if (vecs[i].trig) begin
                exp_cnt++; exp_ch = vecs[i].ch; exp_ts = vecs[i].ts;
            end
            check($sformatf("vec%0d_window", i), dec_log, win(vecs[i].trig ? 10 : -1, -1));
            check($sformatf("vec%0d_channel", i), tch, exp_ch);
            check($sformatf("vec%0d_ts", i), tts, exp_ts);
            check($sformatf("vec%0d_count", i), tcnt, 16'(exp_cnt));
            check($sformatf("vec%0d_frame_err", i), err_any(), 8'h0);
        end
        en = 8'hFF; tbl = 1'b0;

`ifndef THRESH_COINCIDENCE_EN
        // Two spikes on lane 1: one continuous window, a single trigger.
        init_frame(16'h0);
        fw[1][10] = 16'h0200;
        fw[1][14] = 16'h0200;
        play();
        exp_cnt++; exp_ch = 3'd1; exp_ts = 16'h0010;
        check("retrig_window", dec_log, win(10, 14));
        check("retrig_count", tcnt, 16'(exp_cnt));
        check("retrig_ts", tts, exp_ts);
        check("retrig_channel", tch, exp_ch);
`endif

        // Sync loss on lane 0 and a bad END word on lane 1.
        init_frame(16'h0);
        fs[0][20]  = 2'b01;
        fw[0][30]  = 16'h0200;
        fw[1][127] = 16'h1234;
        play();
        begin
            logic [LOG-1:0] e20, e127;
            e20 = '0;  e20[20]   = 1'b1;
            e127 = '0; e127[127] = 1'b1;
            check("syncloss_err_lane0", err_log[0], e20);
            check("badend_err_lane1", err_log[1], e127);
            check("err_other_lanes", err_any() & 8'hFC, 8'h0);
        end
        check("syncloss_no_trigger", dec_log, '0);
        check("syncloss_count", tcnt, 16'(exp_cnt));

        // Reset mid-frame while a window is open; the rest of the frame must be ignored.
        init_frame(16'h0);
        fw[3][35] = 16'h0200; fw[4][35] = 16'h0200;
        fw[3][80] = 16'h0200; fw[4][80] = 16'h0200;
        for (int k = 40; k < 45; k++) frst[k] = 1'b1;
        play();
        begin
            logic [LOG-1:0] ev;
            ev = '0;
            for (int k = 36; k < 40; k++) ev[k] = 1'b1;
            check("midreset_window", dec_log, ev);
        end
        check("midreset_count", tcnt, 16'h0);
        check("midreset_ts", tts, 16'h0);
        check("midreset_channel", tch, 3'd0);
        check("midreset_frame_err", err_any(), 8'h0);
        init_frame(16'h0);
        fw[3][10] = 16'h0200; fw[4][10] = 16'h0200;
        play();
        exp_cnt = 1; exp_ch = 3'd3; exp_ts = 16'h1000;
        check("postreset_window", dec_log, win(10, -1));
        check("postreset_count", tcnt, 16'(exp_cnt));
        check("postreset_ts", tts, exp_ts);
        check("postreset_channel", tch, exp_ch);

        // Randomized streams with independent per-lane fillers.
        rst = 1'b1;
        for (int l = 0; l < NCH; l++) begin w[l] = 16'h0; s[l] = 2'b11; d[l] = 2'b01; end
        repeat (2) step();
        rst = 1'b0;
        exp_cnt = 0; exp_ch = '0; exp_ts = '0;
        prev_hits = '0; dec_prev = 1'b0; last_cond = -1000;
        for (int l = 0; l < NCH; l++) begin
            pos[l] = 0; cur_ts[l] = '0; prev_ts[l] = '0;
        end
        for (int seg = 0; seg < 4; seg++) begin
            en  = (seg == 0) ? 8'hFF : 8'($urandom);
            tbl = 1'($urandom);
            thr = 16'($urandom_range(32'h0080, 32'hFF00));
            for (int it = 0; it < 1000; it++) begin
                int gk;
                gk = seg * 1000 + it;
                hits = '0;
                for (int l = 0; l < NCH; l++) begin
                    hit_ts[l] = cur_ts[l];
                    if ($urandom_range(0, 7) == 0) begin
                        w[l] = 16'($urandom);
                        d[l] = 2'($urandom_range(1, 3));
                        s[l] = (pos[l] == 0 && $urandom_range(0, 1) == 1) ? 2'b01 : 2'b11;
                    end else begin
                        s[l] = 2'b11; d[l] = 2'b00;
                        if (pos[l] == 0) w[l] = 16'hDEAD;
                        else if (pos[l] == 1) begin
                            w[l] = 16'($urandom); cur_ts[l] = w[l];
                        end else if (pos[l] == FL - 1) w[l] = 16'hBEEF;
                        else begin
                            v = tbl ? 16'hFFFF : 16'h0000;
                            if ($urandom_range(0, 299) == 0) begin
                                case ($urandom_range(0, 5))
                                    0: v = thr;
                                    1: v = thr + 16'd1;
                                    2: v = thr - 16'd1;
                                    3: v = 16'hDEAD;
                                    4: v = 16'hBEEF;
                                    default: v = 16'($urandom);
                                endcase
                            end
                            w[l] = v;
                            hits[l] = tbl ? (v < thr) : (v > thr);
                            hit_ts[l] = cur_ts[l];
                        end
                        pos[l] = (pos[l] + 1) % FL;
                    end
                end
                qual = prev_hits & en;
`ifdef THRESH_COINCIDENCE_EN
                cond = ($countones(qual) >= 2);
`else
                cond = (qual != '0);
`endif
                if (cond) begin
                    if (!dec_prev) begin
                        exp_cnt++;
                        exp_ch = 3'(lowest(qual));
                        exp_ts = prev_ts[lowest(qual)];
                    end
                    last_cond = gk;
                end
                dec_exp = (last_cond >= gk - P + 1);
                step();
                check("rand_decision", dec, dec_exp);
                check("rand_count", tcnt, 16'(exp_cnt));
                check("rand_channel", tch, exp_ch);
                check("rand_ts", tts, exp_ts);
                check("rand_frame_err", ferr, 8'h0);
                prev_hits = hits;
                for (int l = 0; l < NCH; l++) prev_ts[l] = hit_ts[l];
                dec_prev = dec_exp;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
